// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, state type and byte-enable helper for the
// sub-word data memory (dmem_subword and dmem_bram).
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    // Byte-enable mask for an aligned access of the width coded in f3
    // starting at byte lane `lane`; unknown codes enable nothing.
    function automatic logic [3:0] be_mask(
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        logic [3:0] m;
        m = 4'b0000;
        case (f3)
            F3_B, F3_BU: m = 4'b0001 << lane;
            F3_H, F3_HU: m = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: DEPTH x 32 word array, byte-enabled synchronous write and
// registered read. Ports: clk, we, be, waddr, raddr, wdata, rdata.
module dmem_bram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-3:0] waddr,
    input  logic [ADDR_W-3:0] raddr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // No reset: contents survive reset unless the owner clears them.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_subword.sv
// dmem_subword: byte-enabled RV32 data memory with post-reset clear,
// valid/ready request, 1-cycle response (rsp_valid/rsp_rdata/rsp_err).
module dmem_subword
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IW = ADDR_W - 2;
    localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_ld_q, rsp_ld_d;
    logic [1:0]    lane_q, lane_d;
    logic [2:0]    f3_q, f3_d;

    logic          accept;
    logic [1:0]    lane;
    logic          f3_ok;
    logic          misalign;
    logic          range_err;
    logic          req_err;
    logic [31:0]   st_data;

    logic          mem_we;
    logic [3:0]    mem_be;
    logic [IW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    assign req_ready = (state_q == ST_RUN);
    assign accept    = req_valid & req_ready;
    assign lane      = req_addr[1:0];

    // Request decode; BU/HU are load-only codes.
    always_comb begin
        f3_ok    = 1'b0;
        misalign = 1'b0;
        case (req_funct3)
            F3_B: f3_ok = 1'b1;
            F3_H: begin
                f3_ok    = 1'b1;
                misalign = lane[0];
            end
            F3_W: begin
                f3_ok    = 1'b1;
                misalign = |lane;
            end
            F3_BU: f3_ok = ~req_we;
            F3_HU: begin
                f3_ok    = ~req_we;
                misalign = lane[0];
            end
            default: f3_ok = 1'b0;
        endcase
        range_err = |req_addr[31:ADDR_W];
        req_err   = ~f3_ok | misalign | range_err;
    end

    // Replicate the store data across lanes; byte enables pick the lanes.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   st_data = {4{req_wdata[7:0]}};
            2'b01:   st_data = {2{req_wdata[15:0]}};
            default: st_data = req_wdata;
        endcase
    end

    // Write port is owned by the clear sweep until RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_waddr = req_addr[ADDR_W-1:2];
        mem_wdata = st_data;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_be    = 4'b1111;
            mem_waddr = clr_idx_q;
            mem_wdata = 32'h0;
        end else if (accept && req_we && !req_err) begin
            mem_we = 1'b1;
            mem_be = be_mask(req_funct3, lane);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + IDX_ONE;
            if (&clr_idx_q) begin
                state_d = ST_RUN;
            end
        end
        rsp_valid_d = accept;
        rsp_err_d   = accept & req_err;
        rsp_ld_d    = accept & ~req_we & ~req_err;
        lane_d      = lane;
        f3_d        = req_funct3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_ld_q    <= 1'b0;
            lane_q      <= 2'b00;
            f3_q        <= 3'b000;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_ld_q    <= rsp_ld_d;
            lane_q      <= lane_d;
            f3_q        <= f3_d;
        end
    end

    dmem_bram #(
        .ADDR_W(ADDR_W)
    ) u_bram (
        .clk  (clk),
        .we   (mem_we),
        .be   (mem_be),
        .waddr(mem_waddr),
        .raddr(req_addr[ADDR_W-1:2]),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    // Extract and extend using the lane/funct3 captured with the request.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_ext = {24'h0, ld_byte};
            F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_ld_q ? ld_ext : 32'h0;

endmodule
